// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: one borrow cell reused over WIDTH cycles, LSB first.
// Optional build macro SERIAL_SUB_SAT_EN: clamp difference to 0 when the final borrow is set.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_d;
    logic             bit_b;
    logic [WIDTH-1:0] res_shift;

    // Two cascaded half-subtractors: (a - b) then (- borrow).
    always_comb begin
        bit_d     = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
        bit_b     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = bit_d;
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = res_shift;
                borrow_d = bit_b;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    bout_d  = bit_b;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d  = bit_b ? '0 : res_shift;
`else
                    diff_d  = res_shift;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign difference = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 vector table, multi-cycle corner sequences, WIDTH=1 table.
module tb_serial_sub_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, bout8;
    logic       busy1, done1, bout1;
    logic [7:0] diff8;
    logic [0:0] diff1;

    int tests;
    int fails;

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .difference(diff8), .borrow_out(bout8)
    );

    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .difference(diff1), .borrow_out(bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_diff8(input logic [7:0] d, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
        return bo ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    // Waits for done on the WIDTH=8 instance; returns edges counted since the accept edge.
    task automatic wait_done8(output int n, input logic [7:0] hold_diff, output logic stable);
        n = 0;
        stable = 1'b1;
        while (!done8 && n < 20) begin
            if (diff8 !== hold_diff) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run8(input vec_t v);
        int n;
        logic stable;
        logic [7:0] prev;
        prev = diff8;
        @(negedge clk);
        a8 = v.a; b8 = v.b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~v.a; b8 = ~v.b;
        check("busy_after_accept", busy8, 1);
        wait_done8(n, prev, stable);
        check("latency8", n, 8);
        check("diff_stable_mid_shift", stable, 1);
        check("diff8", diff8, exp_diff8(v.diff, v.borrow));
        check("borrow8", bout8, v.borrow);
        $display("[TB] job a=%02h b=%02h -> diff=%02h borrow=%0d after %0d edges", v.a, v.b, diff8, bout8, n);
        @(posedge clk); #1;
        check("done_one_cycle", done8, 0);
        check("idle_after_done", busy8, 0);
    endtask

    task automatic run1(input logic av, input logic bv, input logic ed, input logic eb);
        int n;
        @(negedge clk);
        a1 = av; b1 = bv; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency1", n, 1);
        check("diff1", diff1, ed);
        check("borrow1", bout1, eb);
        $display("[TB] w1 a=%0d b=%0d -> diff=%0d borrow=%0d", av, bv, diff1, bout1);
        @(posedge clk); #1;
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        int extra_done;
        logic stable;
        logic [0:0] w1_a[4];
        logic [0:0] w1_b[4];
        logic [0:0] w1_d[4];
        logic [0:0] w1_bo[4];
        tests = 0;
        fails = 0;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[5] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
        vecs[6] = '{8'h01, 8'h00, 8'h01, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 8'h7F, 1'b0};

        w1_a  = '{1'b0, 1'b0, 1'b1, 1'b1};
        w1_b  = '{1'b0, 1'b1, 1'b0, 1'b1};
        w1_d  = '{1'b0, 1'b1, 1'b1, 1'b0};
        w1_bo = '{1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", bout8, 0);
        check("rst_busy1", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run8(vecs[i]);

        // Back-to-back with start held high: second job needs an IDLE cycle first.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        wait_done8(n, diff8, stable);
        check("b2b_lat1", n, 8);
        check("b2b_diff1", diff8, 8'h00);
        check("b2b_borrow1", bout8, 0);
        a8 = 8'h00; b8 = 8'h00;
        @(posedge clk); #1;
        check("b2b_idle_gap", busy8, 0);
        @(posedge clk); #1;
        check("b2b_second_accepted", busy8, 1);
        start8 = 1'b0;
        wait_done8(n, diff8, stable);
        check("b2b_lat2", n, 8);
        check("b2b_diff2", diff8, 8'h00);
        check("b2b_borrow2", bout8, 0);
        $display("[TB] back-to-back FF-FF, 00-00 -> diff=%02h borrow=%0d", diff8, bout8);
        @(posedge clk); #1;

        // Start re-pulsed mid-shift must be ignored.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        #1;
        wait_done8(n, diff8, stable);
        check("ignore_diff", diff8, 8'h7F);
        check("ignore_borrow", bout8, 0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) extra_done++;
        end
        check("ignore_single_done", extra_done, 0);
        check("ignore_idle", busy8, 0);
        $display("[TB] re-pulse during 80-01 -> diff=%02h extra_done=%0d", diff8, extra_done);

        // Leave a nonzero result with borrow set, then reset mid-shift.
        run8(vecs[1]);
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_diff", diff8, 0);
        check("arst_borrow", bout8, 0);
        extra_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) extra_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done8) extra_done++;
        end
        check("arst_no_done", extra_done, 0);
        $display("[TB] reset mid-shift -> diff=%02h borrow=%0d", diff8, bout8);
        run8(vecs[0]);

        for (int i = 0; i < 4; i++) run1(w1_a[i], w1_b[i], w1_d[i], w1_bo[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
